debounce: RTL and testbench



---
 rtl/debounce.sv | 33 +++
 tb/tb_debounce.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/debounce.sv
// Single-bit debouncer: s follows b, then ignores b for HOLD_CYCLES edges
// after every transition so contact bounce cannot toggle the output.
module debounce #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b,
  output logic s
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic             s_q;
  logic [CNT_W-1:0] hold_cnt;

  // While hold_cnt is non-zero b is not looked at; each accepted change reloads the hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= 1'b0;
      hold_cnt <= '0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end else if (b != s_q) begin
      s_q      <= b;
      hold_cnt <= HOLD_LOAD;
    end
  end

  assign s = s_q;

endmodule

// File: tb/tb_debounce.sv
// Scoreboarded bench for debounce: three instances (hold 0, 1, 3) share b and rst_n
// and are compared against an edge-indexed reference model of the ignore window.
module tb_debounce;

  localparam int NDUT = 3;
  localparam int HOLDS [NDUT] = '{0, 1, 3};

  logic clk;
  logic rst_n;
  logic b;
  logic s0, s1, s3;

  int total = 0;
  int bad   = 0;

  logic [NDUT-1:0] expq [$];

  bit mS      [NDUT];
  int lastChg [NDUT];
  int edgeNum;

  debounce #(.HOLD_CYCLES(0), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .b(b), .s(s0));
  debounce #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .b(b), .s(s1));
  debounce #(.HOLD_CYCLES(3), .CNT_W(2)) dut3 (.clk(clk), .rst_n(rst_n), .b(b), .s(s3));

  // 60 ns period, rising edges at 30, 90, 150, ...
  initial begin
    clk = 1'b0;
    forever #30 clk = ~clk;
  end

  function automatic logic [NDUT-1:0] dutOut();
    return {s3, s1, s0};
  endfunction

  task automatic checkOutput(input string name, input logic [NDUT-1:0] actual,
                             input logic [NDUT-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got s{3,1,0}=%b expected %b", name, $time, actual, expected);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < NDUT; k++) begin
      mS[k]      = 1'b0;
      lastChg[k] = -1000;
    end
  endfunction

  // After a change at edge c, edges c+1..c+hold are ignored for that instance.
  function automatic void modelEdge(input bit bv);
    logic [NDUT-1:0] e;
    edgeNum++;
    for (int k = 0; k < NDUT; k++) begin
      if ((edgeNum - lastChg[k] > HOLDS[k]) && (bv != mS[k])) begin
        mS[k]      = bv;
        lastChg[k] = edgeNum;
      end
      e[k] = mS[k];
    end
    expq.push_back(e);
  endfunction

  // Called 2 ns after a rising edge; returns 2 ns after the next one.
  task automatic applyStimulus(input bit val, input bit glitch);
    b = val;
    modelEdge(val);
    if (glitch) begin
      #8  b = ~val;
      #10 b = val;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    modelReset();
    #1 checkOutput("async_reset", dutOut(), '0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 checkOutput("reset_hold", dutOut(), '0);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) checkOutput("scoreboard", dutOut(), expq.pop_front());
    end
  end

  initial begin : watchdog
    #(60 * 5000);
    bad++;
    $display("[TB] FAIL timeout at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    bit dir [$];
    edgeNum = 0;
    modelReset();
    rst_n = 1'b0;
    b     = 1'b0;
    @(posedge clk);
    #2;
    doReset(3);

    // Clean rise, bounce with b=0 at the next edge, settle, falling bounce, clean rise/fall.
    dir = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0,
            1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    foreach (dir[i]) applyStimulus(dir[i], (i % 3) == 1);

    // Rise, then reset while the hold counters are still running.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    doReset(2);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      bit v;
      if ($urandom_range(0, 2) == 0) v = ~b;
      else v = 1'(($urandom_range(0, 3) == 0) ? ~b : b);
      applyStimulus(v, $urandom_range(0, 4) == 0);
    end

    @(posedge clk);
    #3;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
